// File: rtl/fixed_point_muldiv_seq.sv
// Sequential signed Q(INT_W.FRAC_W) multiply / restoring-divide unit with valid/ready handshakes.
// Optional build macro FXP_SAT_EN: saturate results on overflow instead of wrapping.
module fixed_point_muldiv_seq #(
  parameter int unsigned INT_W  = 21,
  parameter int unsigned FRAC_W = 16,
  localparam int unsigned W     = INT_W + FRAC_W,
  localparam int unsigned N     = W + FRAC_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         overflow,
  output logic         div_by_zero
);

  localparam int unsigned CntW = $clog2(N + 2);
  localparam int unsigned PW   = 2 * W - FRAC_W;
  localparam logic [CntW-1:0] CntIter = CntW'(N);
  localparam logic [CntW-1:0] CntLast = CntW'(N + 1);
  localparam logic [W-1:0] MaxV = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MinV = {1'b1, {(W-1){1'b0}}};
  localparam logic [N-1:0] QLim = {{(N-W){1'b0}}, 1'b1, {(W-1){1'b0}}};

  typedef enum logic [2:0] {StIdle, StMul1, StMul2, StDiv, StDz, StDone} state_e;

  state_e                 state_q;
  logic                   in_ready_q, out_valid_q, overflow_q, dz_q, neg_q;
  logic [W-1:0]           result_q, bmag_q, rem_q;
  logic signed [W-1:0]    a_q, b_q;
  logic [PW-1:0]          p_q;
  logic [N-1:0]           dq_q;
  logic [CntW-1:0]        cnt_q;

  logic [W-1:0]           a_mag, b_mag, rem_nxt, mul_res, div_res, div_wrap;
  logic [N-1:0]           dq_nxt;
  logic [W:0]             shifted;
  logic                   ge, mul_ovf, div_ovf;
  logic signed [2*W-1:0]  a_ext, b_ext;

  always_comb begin
    a_mag = a[W-1] ? (~a + 1'b1) : a;
    b_mag = b[W-1] ? (~b + 1'b1) : b;
    a_ext = (2*W)'(a_q);
    b_ext = (2*W)'(b_q);

    // One restoring step: shift the next dividend bit into the partial remainder.
    shifted = {rem_q, dq_q[N-1]};
    ge      = shifted >= {1'b0, bmag_q};
    rem_nxt = W'(shifted - {1'b0, (ge ? bmag_q : {W{1'b0}})});
    dq_nxt  = {dq_q[N-2:0], ge};

    // p_q holds product bits [2W-1:FRAC_W]; the top W-FRAC_W+1 of those must agree.
    mul_ovf  = !((&p_q[PW-1:W-1]) || !(|p_q[PW-1:W-1]));
    div_ovf  = neg_q ? (dq_q > QLim) : (dq_q >= QLim);
    div_wrap = neg_q ? (~dq_q[W-1:0] + 1'b1) : dq_q[W-1:0];
`ifdef FXP_SAT_EN
    mul_res = mul_ovf ? (p_q[PW-1] ? MinV : MaxV) : p_q[W-1:0];
    div_res = div_ovf ? (neg_q ? MinV : MaxV) : div_wrap;
`else
    mul_res = p_q[W-1:0];
    div_res = div_wrap;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      dz_q        <= 1'b0;
      neg_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      bmag_q      <= '0;
      rem_q       <= '0;
      dq_q        <= '0;
      p_q         <= '0;
      cnt_q       <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= b;
            bmag_q     <= b_mag;
            rem_q      <= '0;
            dq_q       <= {a_mag, {FRAC_W{1'b0}}};
            neg_q      <= a[W-1] ^ b[W-1];
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            overflow_q <= 1'b0;
            dz_q       <= 1'b0;
            if (!op)            state_q <= StMul1;
            else if (b == '0)   state_q <= StDz;
            else                state_q <= StDiv;
          end
        end
        StMul1: begin
          p_q     <= PW'((a_ext * b_ext) >>> FRAC_W);
          state_q <= StMul2;
        end
        StMul2: begin
          result_q    <= mul_res;
          overflow_q  <= mul_ovf;
          out_valid_q <= 1'b1;
          state_q     <= StDone;
        end
        StDz: begin
          // Two-cycle dwell keeps divide-by-zero latency equal to multiply.
          if (cnt_q == CntW'(1)) begin
            result_q    <= a_q[W-1] ? MinV : MaxV;
            overflow_q  <= 1'b1;
            dz_q        <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDiv: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q < CntIter) begin
            rem_q <= rem_nxt;
            dq_q  <= dq_nxt;
          end else if (cnt_q == CntLast) begin
            result_q    <= div_res;
            overflow_q  <= div_ovf;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign result      = result_q;
  assign overflow    = overflow_q;
  assign div_by_zero = dz_q;

endmodule

// File: tb/tb_fixed_point_muldiv_seq.sv
// Directed bench for fixed_point_muldiv_seq at default Q21.16; expectations hand-computed.
module tb_fixed_point_muldiv_seq;
  localparam int W = 37;
  localparam logic [W-1:0] MaxV = 37'h0F_FFFF_FFFF;
  localparam logic [W-1:0] MinV = 37'h10_0000_0000;
`ifdef FXP_SAT_EN
  localparam logic [W-1:0] MulOvfRes = MaxV;
  localparam logic [W-1:0] DivOvfRes = MaxV;
`else
  localparam logic [W-1:0] MulOvfRes = 37'h0;
  localparam logic [W-1:0] DivOvfRes = 37'h10_0000_0000;
`endif

  logic         clk = 1'b0;
  logic         reset, in_valid, op, out_ready;
  logic [W-1:0] a, b;
  logic         in_ready, out_valid, overflow, div_by_zero;
  logic [W-1:0] result;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] r_res;
  logic         r_ovf, r_dz;
  int           r_lat, r_busy_rdy;

  fixed_point_muldiv_seq dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .overflow(overflow), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one operation, then wait (bounded) for out_valid.
  task automatic run(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
    in_valid = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    in_valid = 1'b0;
    r_lat = 0; r_busy_rdy = 0;
    while (!out_valid && r_lat < 100) begin
      if (in_ready) r_busy_rdy++;
      @(posedge clk); #1;
      r_lat++;
    end
    r_res = result; r_ovf = overflow; r_dz = div_by_zero;
  endtask

  task automatic release_out;
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; op = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_dz", 64'(div_by_zero), 64'd0);
    reset = 1'b0;

    run(1'b0, 37'h38000, 37'h24000);
    chk("mul1_res", 64'(r_res), 64'h7E000);
    chk("mul1_ovf", 64'(r_ovf), 64'd0);
    chk("mul1_lat", 64'(r_lat), 64'd2);
    release_out;
    chk("mul1_idle", 64'(in_ready), 64'd1);

    run(1'b0, 37'h1F_FFFF_FFFF, 37'h8000);
    chk("mul_lsb_floor", 64'(r_res), 64'h1F_FFFF_FFFF);
    release_out;
    run(1'b0, 37'h1F_FFFE_8000, 37'h8000);
    chk("mul_neg_frac", 64'(r_res), 64'h1F_FFFF_4000);
    chk("mul_neg_ovf", 64'(r_ovf), 64'd0);
    release_out;

    run(1'b1, 37'h70000, 37'h20000);
    chk("div_res", 64'(r_res), 64'h38000);
    chk("div_lat", 64'(r_lat), 64'd55);
    chk("div_busy_rdy", 64'(r_busy_rdy), 64'd0);
    chk("div_ovf", 64'(r_ovf), 64'd0);
    release_out;
    run(1'b1, 37'h1F_FFF9_0000, 37'h20000);
    chk("div_neg_res", 64'(r_res), 64'h1F_FFFC_8000);
    release_out;

    run(1'b1, 37'h50000, 37'h0);
    chk("dz_res", 64'(r_res), 64'(MaxV));
    chk("dz_flag", 64'(r_dz), 64'd1);
    chk("dz_ovf", 64'(r_ovf), 64'd1);
    chk("dz_lat", 64'(r_lat), 64'd2);
    release_out;
    run(1'b1, 37'h1F_FFFB_0000, 37'h0);
    chk("dz_neg_res", 64'(r_res), 64'(MinV));
    release_out;

    out_ready = 1'b0;
    run(1'b0, 37'h08_0000_0000, 37'h40000);
    chk("mulovf_res", 64'(r_res), 64'(MulOvfRes));
    chk("mulovf_flag", 64'(r_ovf), 64'd1);
    chk("mulovf_dz_clr", 64'(r_dz), 64'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("hold_res", 64'(result), 64'(MulOvfRes));
    chk("hold_valid", 64'(out_valid), 64'd1);
    chk("hold_in_ready", 64'(in_ready), 64'd0);
    release_out;
    chk("drain_valid", 64'(out_valid), 64'd0);
    chk("drain_in_ready", 64'(in_ready), 64'd1);

    run(1'b1, 37'h08_0000_0000, 37'h8000);
    chk("divovf_pos_res", 64'(r_res), 64'(DivOvfRes));
    chk("divovf_pos_flag", 64'(r_ovf), 64'd1);
    release_out;
    run(1'b1, 37'h18_0000_0000, 37'h8000);
    chk("div_min_res", 64'(r_res), 64'(MinV));
    chk("div_min_ovf", 64'(r_ovf), 64'd0);
    release_out;
    run(1'b1, 37'h10_0000_0000, 37'h1F_FFFF_0000);
    chk("div_mostneg_res", 64'(r_res), 64'(DivOvfRes));
    chk("div_mostneg_ovf", 64'(r_ovf), 64'd1);
    release_out;

    in_valid = 1'b1; op = 1'b1; a = 37'h70000; b = 37'h20000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_valid", 64'(out_valid), 64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    run(1'b0, 37'h10000, 37'h10000);
    chk("post_rst_res", 64'(r_res), 64'h10000);
    chk("post_rst_lat", 64'(r_lat), 64'd2);
    release_out;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
